// File: rtl/fx_pkg.sv
// Shared defaults and fixed-point helpers for the fx_chain effects pipeline.
// Helpers work on 64-bit signed values; callers size-cast in and out.
package fx_pkg;

  localparam int DEF_IN_W      = 12;
  localparam int DEF_OUT_W     = 16;
  localparam int DEF_GAIN_W    = 11;
  localparam int DEF_GAIN_FRAC = 4;
  localparam int DEF_VOL_W     = 8;
  localparam int DEF_CLIP_HOLD = 4800;

  // Arithmetic right shift by sh (sh >= 1) with round-half-up.
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] a,
                                                     input int unsigned       sh);
    return (a + (64'sd1 <<< (sh - 1))) >>> sh;
  endfunction

  // Clamp a to the range of a w-bit two's complement number.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] a,
                                                    input int unsigned       w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (a > hi) return hi;
    if (a < lo) return lo;
    return a;
  endfunction

endpackage

// File: rtl/fx_clip_hold.sv
// Clip indicator: reloadable hold counter decremented per output sample,
// with a registered LED flag that stays lit while the counter is nonzero.
module fx_clip_hold
  import fx_pkg::*;
#(
  parameter int CLIP_HOLD = DEF_CLIP_HOLD
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic clip_led
);

  localparam int CNT_W = $clog2(CLIP_HOLD + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             led_q, led_d;

  always_comb begin
    cnt_d = cnt_q;
    led_d = (cnt_q != '0);
    // A fresh clip wins over the decrement from the same output sample.
    if (load) begin
      cnt_d = CNT_W'(CLIP_HOLD);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      led_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      led_q <= led_d;
    end
  end

  assign clip_led = led_q;

endmodule

// File: rtl/fx_chain.sv
// Four-stage effects chain: sign-extend, gain, hard clip, volume with
// rounding/saturation. Config travels with each sample; optional bypass.
module fx_chain
  import fx_pkg::*;
#(
  parameter int IN_W      = DEF_IN_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int GAIN_W    = DEF_GAIN_W,
  parameter int GAIN_FRAC = DEF_GAIN_FRAC,
  parameter int VOL_W     = DEF_VOL_W,
  parameter int CLIP_HOLD = DEF_CLIP_HOLD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic signed [IN_W-1:0]  sample_in,
  input  logic [GAIN_W-1:0]       gain,
  input  logic [OUT_W-2:0]        clip_level,
  input  logic [VOL_W-1:0]        vol,
  input  logic                    bypass,
  output logic                    valid_out,
  output logic signed [OUT_W-1:0] sample_out,
  output logic                    clip_led
);

  localparam int P_W = OUT_W + GAIN_W + 1;
  localparam int M_W = OUT_W + VOL_W + 1;

  // Stage 1: sign-extended sample plus captured config.
  logic                    v1_q, v1_d;
  logic signed [OUT_W-1:0] x1_q, x1_d;
  logic [GAIN_W-1:0]       gain1_q, gain1_d;
  logic [OUT_W-2:0]        clip1_q, clip1_d;
  logic [VOL_W-1:0]        vol1_q, vol1_d;
  logic                    byp1_q, byp1_d;

  // Stage 2: full-width gain product.
  logic                    v2_q, v2_d;
  logic signed [P_W-1:0]   p2_q, p2_d;
  logic signed [OUT_W-1:0] x2_q, x2_d;
  logic [OUT_W-2:0]        clip2_q, clip2_d;
  logic [VOL_W-1:0]        vol2_q, vol2_d;
  logic                    byp2_q, byp2_d;

  // Stage 3: clipped sample and clip flag.
  logic                    v3_q, v3_d;
  logic signed [OUT_W-1:0] c3_q, c3_d;
  logic                    flag3_q, flag3_d;
  logic signed [OUT_W-1:0] x3_q, x3_d;
  logic [VOL_W-1:0]        vol3_q, vol3_d;
  logic                    byp3_q, byp3_d;

  // Stage 4: output register.
  logic                    valid_out_q, valid_out_d;
  logic signed [OUT_W-1:0] sample_out_q, sample_out_d;

  logic signed [P_W-1:0]   g;
  logic signed [P_W-1:0]   lvl;
  logic signed [P_W-1:0]   c_full;
  logic signed [M_W-1:0]   m;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it
    // unassigned; that is what keeps this block from inferring latches.
    v1_d         = valid_in;
    x1_d         = x1_q;
    gain1_d      = gain1_q;
    clip1_d      = clip1_q;
    vol1_d       = vol1_q;
    byp1_d       = byp1_q;
    v2_d         = v1_q;
    p2_d         = p2_q;
    x2_d         = x2_q;
    clip2_d      = clip2_q;
    vol2_d       = vol2_q;
    byp2_d       = byp2_q;
    v3_d         = v2_q;
    c3_d         = c3_q;
    flag3_d      = flag3_q;
    x3_d         = x3_q;
    vol3_d       = vol3_q;
    byp3_d       = byp3_q;
    valid_out_d  = v3_q;
    sample_out_d = sample_out_q;
    g            = P_W'(round_shift(64'(p2_q), GAIN_FRAC));
    lvl          = P_W'($signed({1'b0, clip2_q}));
    c_full       = g;
    m            = M_W'(c3_q) * M_W'($signed({1'b0, vol3_q}));

    if (valid_in) begin
      x1_d    = OUT_W'(sample_in);
      gain1_d = gain;
      clip1_d = clip_level;
      vol1_d  = vol;
      byp1_d  = bypass;
    end

    if (v1_q) begin
      p2_d    = P_W'(x1_q) * P_W'($signed({1'b0, gain1_q}));
      x2_d    = x1_q;
      clip2_d = clip1_q;
      vol2_d  = vol1_q;
      byp2_d  = byp1_q;
    end

    if (g > lvl) begin
      c_full = lvl;
    end else if (g < -lvl) begin
      c_full = -lvl;
    end

    if (v2_q) begin
      c3_d    = OUT_W'(c_full);
      flag3_d = (c_full != g);
      x3_d    = x2_q;
      vol3_d  = vol2_q;
      byp3_d  = byp2_q;
    end

    if (v3_q) begin
      sample_out_d = byp3_q ? x3_q
                            : OUT_W'(sat_signed(round_shift(64'(m), VOL_W - 1), OUT_W));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q         <= 1'b0;
      x1_q         <= '0;
      gain1_q      <= '0;
      clip1_q      <= '0;
      vol1_q       <= '0;
      byp1_q       <= 1'b0;
      v2_q         <= 1'b0;
      p2_q         <= '0;
      x2_q         <= '0;
      clip2_q      <= '0;
      vol2_q       <= '0;
      byp2_q       <= 1'b0;
      v3_q         <= 1'b0;
      c3_q         <= '0;
      flag3_q      <= 1'b0;
      x3_q         <= '0;
      vol3_q       <= '0;
      byp3_q       <= 1'b0;
      valid_out_q  <= 1'b0;
      sample_out_q <= '0;
    end else begin
      // NOTE: non-blocking updates so every stage samples the previous
      // stage's old value and the pipeline shifts by exactly one step.
      v1_q         <= v1_d;
      x1_q         <= x1_d;
      gain1_q      <= gain1_d;
      clip1_q      <= clip1_d;
      vol1_q       <= vol1_d;
      byp1_q       <= byp1_d;
      v2_q         <= v2_d;
      p2_q         <= p2_d;
      x2_q         <= x2_d;
      clip2_q      <= clip2_d;
      vol2_q       <= vol2_d;
      byp2_q       <= byp2_d;
      v3_q         <= v3_d;
      c3_q         <= c3_d;
      flag3_q      <= flag3_d;
      x3_q         <= x3_d;
      vol3_q       <= vol3_d;
      byp3_q       <= byp3_d;
      valid_out_q  <= valid_out_d;
      sample_out_q <= sample_out_d;
    end
  end

  fx_clip_hold #(
    .CLIP_HOLD(CLIP_HOLD)
  ) u_clip_hold (
    .clk     (clk),
    .rst     (rst),
    .load    (v3_q & flag3_q & ~byp3_q),
    .dec     (v3_q),
    .clip_led(clip_led)
  );

  assign valid_out  = valid_out_q;
  assign sample_out = sample_out_q;

endmodule

// File: tb/tb_fx_chain.sv
// Self-checking bench for fx_chain: directed cases plus randomized samples,
// compared every cycle against an arithmetic model of the chain.
module tb_fx_chain;

  localparam int IN_W      = 12;
  localparam int OUT_W     = 16;
  localparam int GAIN_W    = 11;
  localparam int GAIN_FRAC = 4;
  localparam int VOL_W     = 8;
  localparam int CLIP_HOLD = 4;
  localparam int LATENCY   = 4;

  logic                    clk;
  logic                    rst;
  logic                    valid_in;
  logic signed [IN_W-1:0]  sample_in;
  logic [GAIN_W-1:0]       gain;
  logic [OUT_W-2:0]        clip_level;
  logic [VOL_W-1:0]        vol;
  logic                    bypass;
  logic                    valid_out;
  logic signed [OUT_W-1:0] sample_out;
  logic                    clip_led;

  fx_chain #(
    .IN_W     (IN_W),
    .OUT_W    (OUT_W),
    .GAIN_W   (GAIN_W),
    .GAIN_FRAC(GAIN_FRAC),
    .VOL_W    (VOL_W),
    .CLIP_HOLD(CLIP_HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .sample_in (sample_in),
    .gain      (gain),
    .clip_level(clip_level),
    .vol       (vol),
    .bypass    (bypass),
    .valid_out (valid_out),
    .sample_out(sample_out),
    .clip_led  (clip_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int due;
    int value;
    bit clipped;
  } exp_t;

  exp_t q[$];
  int   checks;
  int   failures;
  int   cyc;
  int   exp_out;
  bit   have_clip;
  int   since_clip;

  // Reference: the chain's arithmetic rules on plain 64-bit integers.
  function automatic void model(input int s, input int g, input int cl, input int v,
                                input bit byp, output int val, output bit clp);
    longint p, gg, c, r, hi, lo;
    if (byp) begin
      val = s;
      clp = 1'b0;
      return;
    end
    p  = longint'(s) * longint'(g);
    gg = (p + (64'sd1 <<< (GAIN_FRAC - 1))) >>> GAIN_FRAC;
    c  = gg;
    if (gg > cl) c = cl;
    if (gg < -cl) c = -cl;
    clp = (c != gg);
    r  = (c * v + (64'sd1 <<< (VOL_W - 2))) >>> (VOL_W - 1);
    hi = (64'sd1 <<< (OUT_W - 1)) - 1;
    lo = -(64'sd1 <<< (OUT_W - 1));
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    val = int'(r);
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, expv);
    end
  endtask

  // Advance one clock and compare all outputs with the model.
  task automatic tick();
    bit strobe;
    bit clipped;
    int led_exp;
    @(posedge clk);
    cyc++;
    #1;
    led_exp = (have_clip && since_clip < CLIP_HOLD) ? 1 : 0;
    strobe  = (q.size() > 0) && (q[0].due == cyc);
    clipped = 1'b0;
    if (strobe) begin
      exp_out = q[0].value;
      clipped = q[0].clipped;
      void'(q.pop_front());
    end
    check("valid_out", {31'd0, valid_out}, strobe ? 1 : 0);
    check("sample_out", 32'(sample_out), exp_out);
    check("clip_led", {31'd0, clip_led}, led_exp);
    if (strobe) begin
      if (clipped) begin
        have_clip  = 1'b1;
        since_clip = 0;
      end else begin
        since_clip++;
      end
    end
  endtask

  task automatic drive(input int s, input int g, input int cl, input int v, input bit byp);
    int val;
    bit clp;
    valid_in   = 1'b1;
    sample_in  = IN_W'(s);
    gain       = GAIN_W'(g);
    clip_level = (OUT_W - 1)'(cl);
    vol        = VOL_W'(v);
    bypass     = byp;
    model(s, g, cl, v, byp, val, clp);
    q.push_back('{cyc + LATENCY, val, clp});
    tick();
    valid_in = 1'b0;
  endtask

  // Idle cycles scramble the data/config inputs to prove they are ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      valid_in   = 1'b0;
      sample_in  = IN_W'($urandom);
      gain       = GAIN_W'($urandom);
      clip_level = (OUT_W - 1)'($urandom);
      vol        = VOL_W'($urandom);
      bypass     = 1'($urandom);
      tick();
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_out    = 0;
    have_clip  = 1'b0;
    since_clip = 0;
  endtask

  initial begin
    int s, g, cl, v;
    bit byp;
    checks     = 0;
    failures   = 0;
    cyc        = 0;
    model_reset();
    rst        = 1'b0;
    valid_in   = 1'b0;
    sample_in  = '0;
    gain       = '0;
    clip_level = '0;
    vol        = '0;
    bypass     = 1'b0;

    // Reset state, with valid_in asserted to show it is ignored in reset.
    valid_in = 1'b1;
    tick();
    tick();
    valid_in = 1'b0;
    #2 rst = 1'b1;
    idle(2);

    // Unity gain/volume passes full-scale positive input.
    drive(2047, 16, 32767, 128, 1'b0);
    idle(6);

    // Max gain on most-negative input clips at -clip_level.
    drive(-2048, 2047, 32767, 128, 1'b0);
    idle(3);
    drive(0, 16, 32767, 128, 1'b0);
    drive(0, 16, 32767, 128, 1'b0);
    idle(3);
    drive(0, 16, 32767, 128, 1'b0);
    drive(0, 16, 32767, 128, 1'b0);
    drive(0, 16, 32767, 128, 1'b0);
    idle(6);

    // Symmetric clipping, back to back.
    drive(600, 32, 1000, 128, 1'b0);
    drive(-600, 32, 1000, 128, 1'b0);
    idle(6);

    // Half volume, round half up on both signs.
    drive(101, 16, 32767, 64, 1'b0);
    drive(-101, 16, 32767, 64, 1'b0);
    for (int i = 0; i < 4; i++) drive(3, 16, 32767, 128, 1'b0);
    idle(6);

    // Bypass ignores gain/clip and never lights the LED.
    drive(-5, 2047, 100, 128, 1'b1);
    idle(6);

    // Zero gain, zero clip level, zero volume, and over-unity saturation.
    drive(1234, 0, 32767, 128, 1'b0);
    drive(1234, 16, 0, 128, 1'b0);
    drive(1234, 16, 32767, 0, 1'b0);
    drive(2047, 2047, 32767, 255, 1'b0);
    drive(-2048, 2047, 32767, 255, 1'b0);
    idle(8);

    // Randomized samples with random gaps and occasional extreme config.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        s   = int'($urandom_range(0, 4095)) - 2048;
        g   = int'($urandom_range(0, 2047));
        cl  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2000))
                                          : int'($urandom_range(0, 32767));
        v   = int'($urandom_range(0, 255));
        byp = ($urandom_range(0, 7) == 0);
        drive(s, g, cl, v, byp);
      end
    end
    idle(8);

    // Per-sample gain capture, then reset aborting an in-flight sample.
    drive(10, 16, 32767, 128, 1'b0);
    drive(10, 32, 32767, 128, 1'b0);
    drive(10, 48, 32767, 128, 1'b0);
    drive(2047, 2047, 32767, 128, 1'b0);
    idle(5);
    valid_in   = 1'b1;
    sample_in  = 12'sd10;
    gain       = 11'd16;
    clip_level = 15'd32767;
    vol        = 8'd128;
    bypass     = 1'b0;
    @(posedge clk);
    cyc++;
    #1 valid_in = 1'b0;
    #1 rst = 1'b0;
    #1;
    model_reset();
    check("rst_valid_out", {31'd0, valid_out}, 0);
    check("rst_sample_out", 32'(sample_out), 0);
    check("rst_clip_led", {31'd0, clip_led}, 0);
    tick();
    #2 rst = 1'b1;
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
